// File: rtl/register_file_sb.sv
// Register file with x0 hardwired to zero, optional write-to-read forwarding,
// a triggered a0 observation register and a per-register busy scoreboard.
module register_file_sb #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned A0_INDEX      = 10,
    parameter bit          BYPASS        = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] AD1_i,
    input  logic [ADDRESS_WIDTH-1:0] AD2_i,
    input  logic [ADDRESS_WIDTH-1:0] AD3_i,
    input  logic                     WE3_i,
    input  logic [DATA_WIDTH-1:0]    WD3_i,
    input  logic                     TRIGGER_i,
    input  logic                     ISSUE_i,
    input  logic [ADDRESS_WIDTH-1:0] ISSUE_AD_i,
    output logic [DATA_WIDTH-1:0]    RD1_o,
    output logic [DATA_WIDTH-1:0]    RD2_o,
    output logic                     BUSY1_o,
    output logic                     BUSY2_o,
    output logic [DATA_WIDTH-1:0]    a0_o
);

    localparam int unsigned Depth = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] A0Addr = ADDRESS_WIDTH'(A0_INDEX);

    logic [DATA_WIDTH-1:0] regs_q [Depth];
    logic [Depth-1:0]      busy_q, busy_d;
    logic [DATA_WIDTH-1:0] a0_q, a0_d;
    logic                  wr_en;

    // x0 is never written, so regs_q[0] stays at its reset value of zero.
    assign wr_en = WE3_i && (AD3_i != '0);

    // Register storage: cleared on reset, written at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[AD3_i] <= WD3_i;
        end
    end

    // Scoreboard next state: clear on writeback, then set on issue so a newer
    // producer to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[AD3_i] = 1'b0;
        end
        if (ISSUE_i && (ISSUE_AD_i != '0)) begin
            busy_d[ISSUE_AD_i] = 1'b1;
        end
    end

    // a0 capture uses the post-edge register value, so a same-edge write is
    // taken directly from WD3_i independent of BYPASS.
    always_comb begin
        a0_d = a0_q;
        if (TRIGGER_i) begin
            if (wr_en && (AD3_i == A0Addr)) begin
                a0_d = WD3_i;
            end else begin
                a0_d = regs_q[A0Addr];
            end
        end
    end

    // Scoreboard and a0 state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            a0_q   <= '0;
        end else begin
            busy_q <= busy_d;
            a0_q   <= a0_d;
        end
    end

    // Combinational read ports with optional forwarding; x0 overrides all.
    always_comb begin
        RD1_o   = regs_q[AD1_i];
        BUSY1_o = busy_q[AD1_i];
        if (BYPASS && WE3_i && (AD3_i == AD1_i)) begin
            RD1_o   = WD3_i;
            BUSY1_o = 1'b0;
        end
        if (AD1_i == '0) begin
            RD1_o   = '0;
            BUSY1_o = 1'b0;
        end

        RD2_o   = regs_q[AD2_i];
        BUSY2_o = busy_q[AD2_i];
        if (BYPASS && WE3_i && (AD3_i == AD2_i)) begin
            RD2_o   = WD3_i;
            BUSY2_o = 1'b0;
        end
        if (AD2_i == '0) begin
            RD2_o   = '0;
            BUSY2_o = 1'b0;
        end
    end

    assign a0_o = a0_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: one instance with forwarding, one without,
// driven from shared inputs and compared against an array-based model.
module tb_register_file_sb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] ad1 = '0, ad2 = '0, ad3 = '0, iad = '0;
    logic          we = 1'b0, trig = 1'b0, issue = 1'b0;
    logic [DW-1:0] wd3 = '0;

    logic [DW-1:0] rd1_b, rd2_b, a0_b, rd1_n, rd2_n, a0_n;
    logic          b1_b, b2_b, b1_n, b2_n;

    int n_checks = 0;
    int n_fail = 0;

    // Model state
    logic [DW-1:0] m_reg [32];
    logic          m_busy [32];
    logic [DW-1:0] m_a0;

    register_file_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .A0_INDEX(10), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .AD1_i(ad1), .AD2_i(ad2), .AD3_i(ad3), .WE3_i(we),
        .WD3_i(wd3), .TRIGGER_i(trig), .ISSUE_i(issue), .ISSUE_AD_i(iad),
        .RD1_o(rd1_b), .RD2_o(rd2_b), .BUSY1_o(b1_b), .BUSY2_o(b2_b), .a0_o(a0_b)
    );

    register_file_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .A0_INDEX(10), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .AD1_i(ad1), .AD2_i(ad2), .AD3_i(ad3), .WE3_i(we),
        .WD3_i(wd3), .TRIGGER_i(trig), .ISSUE_i(issue), .ISSUE_AD_i(iad),
        .RD1_o(rd1_n), .RD2_o(rd2_n), .BUSY1_o(b1_n), .BUSY2_o(b2_n), .a0_o(a0_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we && ad3 == a) return wd3;
        return m_reg[a];
    endfunction

    function automatic logic m_bsy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && we && ad3 == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_a0 = '0;
    endtask

    // Apply the effect of one rising edge to the model.
    task automatic m_edge();
        if (we && ad3 != 0) begin
            m_reg[ad3]  = wd3;
            m_busy[ad3] = 1'b0;
        end
        if (issue && iad != 0) m_busy[iad] = 1'b1;
        if (trig) m_a0 = m_reg[10];
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rd1_b"}, rd1_b, m_rd(ad1, 1'b1));
        chk({tag, ".rd2_b"}, rd2_b, m_rd(ad2, 1'b1));
        chk({tag, ".b1_b"}, DW'(b1_b), DW'(m_bsy(ad1, 1'b1)));
        chk({tag, ".b2_b"}, DW'(b2_b), DW'(m_bsy(ad2, 1'b1)));
        chk({tag, ".a0_b"}, a0_b, m_a0);
        chk({tag, ".rd1_n"}, rd1_n, m_rd(ad1, 1'b0));
        chk({tag, ".rd2_n"}, rd2_n, m_rd(ad2, 1'b0));
        chk({tag, ".b1_n"}, DW'(b1_n), DW'(m_bsy(ad1, 1'b0)));
        chk({tag, ".b2_n"}, DW'(b2_n), DW'(m_bsy(ad2, 1'b0)));
        chk({tag, ".a0_n"}, a0_n, m_a0);
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] ad3;
        logic [DW-1:0] wd3;
        logic          trig;
        logic          issue;
        logic [AW-1:0] iad;
        logic [AW-1:0] ad1;
        logic [AW-1:0] ad2;
        logic [DW-1:0] e_rd1;
        logic [DW-1:0] e_rd2;
        logic          e_b1;
        logic          e_b2;
        logic [DW-1:0] e_a0;
    } vec_t;

    vec_t vecs [15];

    initial begin
        // Expected values are pre-edge outputs of the forwarding instance.
        vecs[0]  = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 1'b1, 5'd0, 5'd0,  5'd0,
                     32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0, 1'b0, 1'b0, 5'd0, 5'd0,  5'd0,
                     32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 5'd5,  32'h12345678, 1'b0, 1'b0, 5'd0, 5'd5,  5'd5,
                     32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0, 1'b0, 1'b0, 5'd0, 5'd5,  5'd5,
                     32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 5'd10, 32'h7, 1'b0, 1'b0, 5'd0, 5'd10, 5'd5,
                     32'h7, 32'h12345678, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 5'd10, 32'h9, 1'b1, 1'b0, 5'd0, 5'd10, 5'd10,
                     32'h9, 32'h9, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 5'd10, 32'h3, 1'b0, 1'b0, 5'd0, 5'd10, 5'd0,
                     32'h3, 32'h0, 1'b0, 1'b0, 32'h9};
        vecs[7]  = '{1'b0, 5'd0,  32'h0, 1'b0, 1'b1, 5'd7, 5'd10, 5'd7,
                     32'h3, 32'h0, 1'b0, 1'b0, 32'h9};
        vecs[8]  = '{1'b0, 5'd0,  32'h0, 1'b0, 1'b0, 5'd0, 5'd7,  5'd7,
                     32'h0, 32'h0, 1'b1, 1'b1, 32'h9};
        vecs[9]  = '{1'b1, 5'd7,  32'hAAAA5555, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7,
                     32'hAAAA5555, 32'hAAAA5555, 1'b0, 1'b0, 32'h9};
        vecs[10] = '{1'b0, 5'd0,  32'h0, 1'b0, 1'b0, 5'd0, 5'd7,  5'd10,
                     32'hAAAA5555, 32'h3, 1'b0, 1'b0, 32'h9};
        vecs[11] = '{1'b1, 5'd7,  32'h11112222, 1'b0, 1'b1, 5'd7, 5'd7, 5'd0,
                     32'h11112222, 32'h0, 1'b0, 1'b0, 32'h9};
        vecs[12] = '{1'b0, 5'd0,  32'h0, 1'b0, 1'b0, 5'd0, 5'd7,  5'd7,
                     32'h11112222, 32'h11112222, 1'b1, 1'b1, 32'h9};
        vecs[13] = '{1'b0, 5'd0,  32'h0, 1'b1, 1'b0, 5'd0, 5'd0,  5'd7,
                     32'h0, 32'h11112222, 1'b0, 1'b1, 32'h9};
        vecs[14] = '{1'b0, 5'd0,  32'h0, 1'b0, 1'b0, 5'd0, 5'd31, 5'd7,
                     32'h0, 32'h11112222, 1'b0, 1'b1, 32'h3};

        m_reset();

        // Asynchronous reset with no clock edge.
        ad1 = 5'd3;
        ad2 = 5'd9;
        #2 rst_n = 1'b0;
        #1;
        chk("reset.rd1", rd1_b, 32'h0);
        chk("reset.rd2", rd2_b, 32'h0);
        chk("reset.busy1", DW'(b1_b), 32'h0);
        chk("reset.busy2", DW'(b2_b), 32'h0);
        chk("reset.a0", a0_b, 32'h0);
        chk("reset.a0_nb", a0_n, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            we = vecs[i].we; ad3 = vecs[i].ad3; wd3 = vecs[i].wd3;
            trig = vecs[i].trig; issue = vecs[i].issue; iad = vecs[i].iad;
            ad1 = vecs[i].ad1; ad2 = vecs[i].ad2;
            #1;
            chk($sformatf("vec%0d.rd1", i), rd1_b, vecs[i].e_rd1);
            chk($sformatf("vec%0d.rd2", i), rd2_b, vecs[i].e_rd2);
            chk($sformatf("vec%0d.busy1", i), DW'(b1_b), DW'(vecs[i].e_b1));
            chk($sformatf("vec%0d.busy2", i), DW'(b2_b), DW'(vecs[i].e_b2));
            chk($sformatf("vec%0d.a0", i), a0_b, vecs[i].e_a0);
            check_model($sformatf("vec%0d.model", i));
            tick();
        end

        // No-forwarding instance: old value before the edge, new after.
        we = 1'b1; ad3 = 5'd20; wd3 = 32'hCAFEF00D; trig = 1'b0; issue = 1'b0;
        ad1 = 5'd20; ad2 = 5'd20;
        #1;
        chk("nobyp.rd1_pre", rd1_n, 32'h0);
        chk("nobyp.rd2_pre", rd2_n, 32'h0);
        chk("byp.rd1_pre", rd1_b, 32'hCAFEF00D);
        tick();
        we = 1'b0;
        #1;
        chk("nobyp.rd1_post", rd1_n, 32'hCAFEF00D);
        chk("nobyp.rd2_post", rd2_n, 32'hCAFEF00D);
        issue = 1'b1; iad = 5'd20;
        tick();
        issue = 1'b0; we = 1'b1; wd3 = 32'h1;
        #1;
        chk("nobyp.busy_during_wb", DW'(b1_n), 32'h1);
        chk("byp.busy_during_wb", DW'(b1_b), 32'h0);
        tick();
        we = 1'b0;
        #1;
        chk("nobyp.busy_after_wb", DW'(b1_n), 32'h0);

        // Reset between edges discards busy bit and data of reg3.
        we = 1'b1; ad3 = 5'd3; wd3 = 32'h55;
        tick();
        we = 1'b0; issue = 1'b1; iad = 5'd3;
        tick();
        issue = 1'b0; ad1 = 5'd3; ad2 = 5'd3;
        #1;
        chk("midrst.busy_before", DW'(b1_b), 32'h1);
        chk("midrst.rd_before", rd1_b, 32'h55);
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        chk("midrst.busy_after", DW'(b1_b), 32'h0);
        chk("midrst.rd_after", rd1_b, 32'h0);
        chk("midrst.rd_after_nb", rd2_n, 32'h0);
        check_model("midrst.model");
        @(negedge clk);
        rst_n = 1'b1;
        we = 1'b1; ad3 = 5'd3; wd3 = 32'h77;
        tick();
        we = 1'b0;
        #1;
        chk("midrst.first_write", rd1_b, 32'h77);
        chk("midrst.first_write_nb", rd1_n, 32'h77);

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            we    = 1'($urandom_range(0, 1));
            ad3   = AW'($urandom_range(0, 31));
            wd3   = $urandom;
            trig  = ($urandom_range(0, 3) == 0);
            issue = 1'($urandom_range(0, 1));
            iad   = AW'($urandom_range(0, 31));
            ad1   = ($urandom_range(0, 3) == 0) ? ad3 : AW'($urandom_range(0, 31));
            ad2   = ($urandom_range(0, 3) == 0) ? ad1 : AW'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) ad3 = 5'd10;
            #1;
            check_model($sformatf("rand%0d", c));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
